// File: rtl/msrv_32_instr_fetch_buffer_if.sv
// Fetch-buffer bus: instruction-memory request/response plus decode-side handshake.
// No storage; pure signal bundle.
// master = fetch buffer (drives requests and head outputs), slave = memory/decode side.
interface msrv_32_instr_fetch_buffer_if;
    logic        redirect_in;
    logic [31:0] pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    modport master (
        input  redirect_in, pc_in, imem_ready_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
        output imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out
    );

    modport slave (
        output redirect_in, pc_in, imem_ready_in, imem_rvalid_in, imem_rdata_in, instr_ready_in,
        input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, pc_out
    );
endinterface

// File: rtl/msrv_32_instr_fetch_buffer.sv
// In-order instruction fetch front-end with a DEPTH-entry {pc,instr} FIFO and redirect flush.
// Latency: head visible 1 cycle after response (3 cycles redirect-to-valid on zero-wait memory).
// Backpressure: requests are credit-limited so count+outstanding never exceeds DEPTH.
module msrv_32_instr_fetch_buffer #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] BOOT_PC = 32'h0000_0000,
    parameter logic [31:0] NOP     = 32'h0000_0013
) (
    input  logic                                ms_riscv32_mp_clk_in,
    input  logic                                ms_riscv32_mp_rst_in,
    msrv_32_instr_fetch_buffer_if.master        bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic          run;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;

    logic          issue;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;
    logic          valid;
    logic [CW-1:0] outstanding_nxt;
    logic [31:0]   target;

    // Handshake decode: credit check, response routing (keep or discard) and pop qualification.
    always_comb begin
        target          = bus.pc_in & ~32'h0000_0003;
        valid           = (count != '0);
        issue           = run & ~bus.redirect_in &
                          (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
        accept          = issue & bus.imem_ready_in;
        // A response with nothing outstanding belongs to a request issued before reset.
        resp            = bus.imem_rvalid_in & (outstanding != '0);
        push            = resp & ~bus.redirect_in & (drop == '0);
        pop             = valid & bus.instr_ready_in & ~bus.redirect_in;
        outstanding_nxt = outstanding + CW'(accept) - CW'(resp);
    end

    assign bus.imem_req_out    = issue;
    assign bus.imem_addr_out   = fetch_pc;
    assign bus.instr_valid_out = valid;
    assign bus.instr_out       = valid ? fifo_instr[rd_ptr] : NOP;
    assign bus.pc_out          = valid ? fifo_pc[rd_ptr]    : 32'h0;

    // Control state: PCs, pointers and counters; a redirect flushes the FIFO and
    // marks every word still in flight as stale.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            run         <= 1'b0;
            fetch_pc    <= BOOT_PC;
            resp_pc     <= BOOT_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding_nxt;
            if (bus.redirect_in) begin
                fetch_pc <= target;
                resp_pc  <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= outstanding_nxt;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
                if (resp && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head outputs.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= bus.imem_rdata_in;
        end
    end

endmodule

// File: tb/tb_msrv_32_instr_fetch_buffer.sv
// Bench for the fetch buffer: in-order memory model plus a stream model of what decode must see.
// Decode must observe the sequential word stream starting at the last reset/redirect target.
// Stimulus mixes directed scenarios with randomized ready/response/redirect traffic.
module tb_msrv_32_instr_fetch_buffer;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] BOOT_PC = 32'h0000_0000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    msrv_32_instr_fetch_buffer_if bus ();

    msrv_32_instr_fetch_buffer #(
        .DEPTH   (DEPTH),
        .BOOT_PC (BOOT_PC),
        .NOP     (NOP)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .bus                  (bus)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem_q [$];
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic        post_redir;
    int          rdy_pct, resp_pct, dec_pct, redir_pm;
    logic        force_redir;
    logic [31:0] force_tgt;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_instr, s_pc;
    int          acc_cnt, pop_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_reset_outputs();
        check_eq("rst_req",   {31'b0, bus.imem_req_out},    0);
        check_eq("rst_addr",  bus.imem_addr_out,            BOOT_PC);
        check_eq("rst_valid", {31'b0, bus.instr_valid_out}, 0);
        check_eq("rst_instr", bus.instr_out,                NOP);
        check_eq("rst_pc",    bus.pc_out,                   0);
    endtask

    // Choose this cycle's inputs; called just after the active edge.
    task automatic drive();
        bus.imem_ready_in  = ($urandom_range(99) < rdy_pct);
        bus.imem_rvalid_in = (mem_q.size() != 0) && ($urandom_range(99) < resp_pct);
        bus.imem_rdata_in  = bus.imem_rvalid_in ? mem_data(mem_q[0]) : $urandom;
        bus.instr_ready_in = ($urandom_range(99) < dec_pct);
        bus.pc_in          = $urandom;
        if (force_redir) begin
            bus.redirect_in = 1'b1;
            bus.pc_in       = force_tgt;
            force_redir     = 1'b0;
        end else begin
            bus.redirect_in = ($urandom_range(999) < redir_pm);
            if (bus.redirect_in && $urandom_range(3) == 0)
                bus.pc_in = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        end
    endtask

    // Sample on the falling edge, check against the models, then advance the models.
    task automatic cycle();
        @(negedge clk);
        s_req   = bus.imem_req_out;
        s_addr  = bus.imem_addr_out;
        s_valid = bus.instr_valid_out;
        s_instr = bus.instr_out;
        s_pc    = bus.pc_out;
        if (!rst_n) begin
            check_reset_outputs();
        end else begin
            if (bus.redirect_in) check_eq("req_during_redirect", {31'b0, s_req}, 0);
            if (s_req)           check_eq("req_addr", s_addr, exp_addr);
            if (post_redir)      check_eq("valid_after_redirect", {31'b0, s_valid}, 0);
            if (!s_valid) begin
                check_eq("empty_instr", s_instr, NOP);
                check_eq("empty_pc",    s_pc,    0);
            end else if (bus.instr_ready_in && !bus.redirect_in) begin
                check_eq("pop_pc",    s_pc,    exp_pc);
                check_eq("pop_instr", s_instr, mem_data(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pop_cnt++;
            end
            if (bus.imem_rvalid_in) void'(mem_q.pop_front());
            if (s_req && bus.imem_ready_in) begin
                mem_q.push_back(s_addr);
                exp_addr = exp_addr + 32'd4;
                acc_cnt++;
            end
            check_eq("credit", {31'b0, (mem_q.size() <= DEPTH)}, 1);
            post_redir = bus.redirect_in;
            if (bus.redirect_in) begin
                exp_addr = bus.pc_in & ~32'h3;
                exp_pc   = bus.pc_in & ~32'h3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            drive();
            cycle();
        end
    endtask

    // Assert reset now (checking the asynchronous effect), hold two cycles, release.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        mem_q.delete();
        exp_addr   = BOOT_PC;
        exp_pc     = BOOT_PC;
        post_redir = 1'b0;
        run_cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        int first;
        bus.redirect_in    = 1'b0;
        bus.pc_in          = '0;
        bus.imem_ready_in  = 1'b0;
        bus.imem_rvalid_in = 1'b0;
        bus.imem_rdata_in  = '0;
        bus.instr_ready_in = 1'b0;
        force_redir = 1'b0;
        force_tgt   = '0;
        acc_cnt = 0;
        pop_cnt = 0;
        rdy_pct = 100; resp_pct = 100; dec_pct = 100; redir_pm = 0;
        #2;
        @(posedge clk);
        #1;

        // Reset release with zero-wait memory: first valid on cycle 3, then 1 instr/cycle.
        do_reset();
        first   = -1;
        pop_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            drive();
            cycle();
            if (s_valid && first < 0) first = i;
        end
        check_eq("first_valid_cycle", first, 3);
        check_eq("stream_pops", pop_cnt, 12);

        // Decode stalled: exactly DEPTH accepts, then one pop frees one request slot.
        do_reset();
        dec_pct = 0;
        acc_cnt = 0;
        run_cycles(10);
        check_eq("stall_accepts", acc_cnt, DEPTH);
        check_eq("stall_req", {31'b0, s_req}, 0);
        dec_pct = 100;
        run_cycles(1);
        check_eq("stall_pop_valid", {31'b0, s_valid}, 1);
        dec_pct = 0;
        run_cycles(1);
        check_eq("resume_req", {31'b0, s_req}, 1);
        check_eq("resume_accepts", acc_cnt, DEPTH + 1);
        run_cycles(1);
        check_eq("refull_req", {31'b0, s_req}, 0);

        // Redirect to 0x102 with two requests in flight: both old words are dropped.
        do_reset();
        dec_pct = 100; resp_pct = 0;
        for (int i = 0; i < 10 && mem_q.size() < 2; i++) run_cycles(1);
        check_eq("inflight_before_redirect", mem_q.size(), 2);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_0102;
        run_cycles(1);
        resp_pct = 100;
        pop_cnt  = 0;
        run_cycles(1);
        check_eq("redirect_next_addr", s_addr, 32'h0000_0100);
        run_cycles(11);
        check_eq("redirect_pops", {31'b0, (pop_cnt >= 6)}, 1);

        // Redirect coincident with a response on a streaming zero-wait memory.
        do_reset();
        run_cycles(6);
        force_redir = 1'b1;
        force_tgt   = 32'h0000_2000;
        pop_cnt     = 0;
        run_cycles(1);
        check_eq("coincident_rvalid", {31'b0, bus.imem_rvalid_in}, 1);
        run_cycles(10);
        check_eq("coincident_pops", {31'b0, (pop_cnt >= 6)}, 1);

        // Fetch PC wraps past 0xFFFF_FFFC to 0.
        do_reset();
        force_redir = 1'b1;
        force_tgt   = 32'hFFFF_FFF8;
        pop_cnt     = 0;
        run_cycles(12);
        check_eq("wrap_pops", {31'b0, (pop_cnt >= 6)}, 1);
        check_eq("wrap_exp_pc_small", {31'b0, (exp_pc < 32'h40)}, 1);

        // Reset mid-stream with three words buffered; fetch restarts at BOOT_PC.
        do_reset();
        dec_pct = 0;
        run_cycles(5);
        dec_pct = 100;
        pop_cnt = 0;
        do_reset();
        run_cycles(10);
        check_eq("post_reset_pops", {31'b0, (pop_cnt >= 6)}, 1);

        // Randomized traffic with redirects.
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            rdy_pct  = $urandom_range(100, 30);
            resp_pct = $urandom_range(100, 30);
            dec_pct  = $urandom_range(100, 20);
            redir_pm = 30;
            run_cycles(75);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
